// File: rtl/brq_pkg.sv
// Shared types and stall codes for the decode-side hazard sequencer.
package brq_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_LDST = 2'd1,
        WAIT_WB   = 2'd2,
        DRAIN     = 2'd3
    } hzd_state_e;

    localparam logic [1:0] STALL_NONE  = 2'b00;
    localparam logic [1:0] STALL_LDUSE = 2'b01;
    localparam logic [1:0] STALL_MEMLD = 2'b10;

endpackage

// File: rtl/brq_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module brq_sat_counter #(
    parameter int Width = 8
) (
    input  logic             brq_clk,
    input  logic             brq_rst,
    input  logic             clr,
    input  logic             en,
    output logic [Width-1:0] cnt
);

    always_ff @(posedge brq_clk) begin
        if (brq_rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + Width'(1);
        end
    end

endmodule

// File: rtl/brq_hazard_ctrl.sv
// Decode-side hazard sequencer: stall freeze/bubble, deferred redirect flush,
// stall watchdog and saturating stall-cycle counter.
module brq_hazard_ctrl
    import brq_pkg::*;
#(
    parameter int MaxStallCycles = 64,
    parameter int CntWidth       = 32
) (
    input  logic                brq_clk,
    input  logic                brq_rst,
    input  logic [1:0]          idu_check_stall,
    input  logic                idu_flush,
    input  logic                ldst_resume,
    input  logic                wb_resume,
    output logic                hzd_freeze_if,
    output logic                hzd_bubble_ex,
    output logic                hzd_flush_if,
    output logic [1:0]          hzd_state,
    output logic [CntWidth-1:0] hzd_stall_cnt,
    output logic                hzd_timeout
);

    localparam int WdWidth = (MaxStallCycles > 2) ? $clog2(MaxStallCycles) : 1;

    hzd_state_e         state_q, state_d;
    logic               pend_flush_q, pend_flush_d;
    logic               timeout_set;
    logic               wd_clr;
    logic               in_wait;
    logic               resumed;
    logic               freeze_c, bubble_c, flush_c;
    logic [WdWidth-1:0] wd_cnt;

    assign in_wait = (state_q == WAIT_LDST) || (state_q == WAIT_WB);
    assign resumed = (state_q == WAIT_LDST) ? ldst_resume : wb_resume;

    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            state_q      <= RUN;
            pend_flush_q <= 1'b0;
            hzd_timeout  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_flush_q <= pend_flush_d;
            if (timeout_set) begin
                hzd_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_flush_d = pend_flush_q;
        timeout_set  = 1'b0;
        wd_clr       = 1'b0;
        freeze_c     = 1'b0;
        bubble_c     = 1'b0;
        flush_c      = 1'b0;
        case (state_q)
            RUN: begin
                // A redirect overrides any stall request raised in the same cycle.
                if (idu_flush) begin
                    flush_c = 1'b1;
                end else begin
                    case (idu_check_stall)
                        STALL_LDUSE: begin
                            freeze_c = 1'b1;
                            bubble_c = 1'b1;
                            wd_clr   = 1'b1;
                            state_d  = WAIT_LDST;
                        end
                        STALL_MEMLD: begin
                            freeze_c = 1'b1;
                            bubble_c = 1'b1;
                            wd_clr   = 1'b1;
                            state_d  = WAIT_WB;
                        end
                        STALL_NONE: ;
                        default: ;
                    endcase
                end
            end
            WAIT_LDST, WAIT_WB: begin
                freeze_c = 1'b1;
                bubble_c = 1'b1;
                if (idu_flush) begin
                    pend_flush_d = 1'b1;
                end
                if (resumed) begin
                    state_d = DRAIN;
                end else if (wd_cnt == WdWidth'(MaxStallCycles - 1)) begin
                    timeout_set = 1'b1;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                flush_c      = pend_flush_q | idu_flush;
                pend_flush_d = 1'b0;
                state_d      = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign hzd_freeze_if = freeze_c & ~brq_rst;
    assign hzd_bubble_ex = bubble_c & ~brq_rst;
    assign hzd_flush_if  = flush_c & ~brq_rst;
    assign hzd_state     = state_q;

    brq_sat_counter #(
        .Width (WdWidth)
    ) u_wd_cnt (
        .brq_clk (brq_clk),
        .brq_rst (brq_rst),
        .clr     (wd_clr),
        .en      (in_wait),
        .cnt     (wd_cnt)
    );

    brq_sat_counter #(
        .Width (CntWidth)
    ) u_stall_cnt (
        .brq_clk (brq_clk),
        .brq_rst (brq_rst),
        .clr     (1'b0),
        .en      (hzd_freeze_if),
        .cnt     (hzd_stall_cnt)
    );

endmodule

// File: tb/tb_brq_hazard_ctrl.sv
// Bench for brq_hazard_ctrl: directed scenarios plus random traffic against a
// stall-tracking reference model, on a small and a default-sized instance.
module tb_brq_hazard_ctrl;

    logic        brq_clk = 1'b0;
    logic        brq_rst;
    logic [1:0]  idu_check_stall;
    logic        idu_flush, ldst_resume, wb_resume;

    logic        s_freeze, s_bubble, s_flush, s_timeout;
    logic [1:0]  s_state;
    logic [3:0]  s_cnt;
    logic        b_freeze, b_bubble, b_flush, b_timeout;
    logic [1:0]  b_state;
    logic [31:0] b_cnt;

    int tests_run = 0;
    int failures  = 0;
    int big_flush_pulses = 0;

    always #5 brq_clk = ~brq_clk;

    brq_hazard_ctrl #(.MaxStallCycles(8), .CntWidth(4)) u_small (
        .brq_clk(brq_clk), .brq_rst(brq_rst), .idu_check_stall(idu_check_stall),
        .idu_flush(idu_flush), .ldst_resume(ldst_resume), .wb_resume(wb_resume),
        .hzd_freeze_if(s_freeze), .hzd_bubble_ex(s_bubble), .hzd_flush_if(s_flush),
        .hzd_state(s_state), .hzd_stall_cnt(s_cnt), .hzd_timeout(s_timeout)
    );

    brq_hazard_ctrl #(.MaxStallCycles(64), .CntWidth(32)) u_big (
        .brq_clk(brq_clk), .brq_rst(brq_rst), .idu_check_stall(idu_check_stall),
        .idu_flush(idu_flush), .ldst_resume(ldst_resume), .wb_resume(wb_resume),
        .hzd_freeze_if(b_freeze), .hzd_bubble_ex(b_bubble), .hzd_flush_if(b_flush),
        .hzd_state(b_state), .hzd_stall_cnt(b_cnt), .hzd_timeout(b_timeout)
    );

    // Reference model: what the pipeline is waiting on, not how the FSM encodes it.
    typedef struct {
        int     kind;       // 0 nothing, 1 load data from LSU, 2 writeback data
        bit     drain;
        int     waited;
        bit     pend;
        bit     tmo;
        longint cnt;
        int     max_stall;
        longint cnt_max;
    } model_t;

    model_t m_s, m_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_out(input model_t m, input bit rst, input int code, input bit fl,
                                      output bit fz, output bit bb, output bit fs);
        fz = 0; bb = 0; fs = 0;
        if (rst) return;
        if (m.drain) fs = m.pend | fl;
        else if (m.kind != 0) begin fz = 1; bb = 1; end
        else if (fl) fs = 1;
        else if (code == 1 || code == 2) begin fz = 1; bb = 1; end
    endfunction

    function automatic model_t model_step(input model_t m, input bit rst, input int code,
                                          input bit fl, input bit lr, input bit wr);
        bit fz, bb, fs;
        model_t n = m;
        if (rst) begin
            n.kind = 0; n.drain = 0; n.waited = 0; n.pend = 0; n.tmo = 0; n.cnt = 0;
            return n;
        end
        model_out(m, rst, code, fl, fz, bb, fs);
        if (fz && n.cnt < n.cnt_max) n.cnt = n.cnt + 1;
        if (m.drain) begin
            n.drain = 0; n.pend = 0;
        end else if (m.kind != 0) begin
            if (fl) n.pend = 1;
            if ((m.kind == 1) ? lr : wr) begin
                n.kind = 0; n.drain = 1;
            end else if (m.waited == m.max_stall - 1) begin
                n.kind = 0; n.drain = 1; n.tmo = 1;
            end else begin
                n.waited = m.waited + 1;
            end
        end else if (!fl && (code == 1 || code == 2)) begin
            n.kind = code; n.waited = 0;
        end
        return n;
    endfunction

    function automatic int model_state(input model_t m);
        return m.drain ? 3 : m.kind;
    endfunction

    task automatic cyc(input bit rst, input int code, input bit fl, input bit lr, input bit wr);
        bit fz, bb, fs;
        brq_rst = rst; idu_check_stall = 2'(code); idu_flush = fl;
        ldst_resume = lr; wb_resume = wr;
        @(negedge brq_clk);
        model_out(m_s, rst, code, fl, fz, bb, fs);
        check("s_freeze", 64'(s_freeze), 64'(fz));
        check("s_bubble", 64'(s_bubble), 64'(bb));
        check("s_flush", 64'(s_flush), 64'(fs));
        check("s_state", 64'(s_state), 64'(model_state(m_s)));
        check("s_cnt", 64'(s_cnt), 64'(m_s.cnt));
        check("s_timeout", 64'(s_timeout), 64'(m_s.tmo));
        model_out(m_b, rst, code, fl, fz, bb, fs);
        check("b_freeze", 64'(b_freeze), 64'(fz));
        check("b_bubble", 64'(b_bubble), 64'(bb));
        check("b_flush", 64'(b_flush), 64'(fs));
        check("b_state", 64'(b_state), 64'(model_state(m_b)));
        check("b_cnt", 64'(b_cnt), 64'(m_b.cnt));
        check("b_timeout", 64'(b_timeout), 64'(m_b.tmo));
        if (b_flush === 1'b1) big_flush_pulses++;
        m_s = model_step(m_s, rst, code, fl, lr, wr);
        m_b = model_step(m_b, rst, code, fl, lr, wr);
        @(posedge brq_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        m_s = '{kind: 0, drain: 0, waited: 0, pend: 0, tmo: 0, cnt: 0, max_stall: 8,  cnt_max: 15};
        m_b = '{kind: 0, drain: 0, waited: 0, pend: 0, tmo: 0, cnt: 0, max_stall: 64, cnt_max: 64'hFFFF_FFFF};
        brq_rst = 1; idu_check_stall = 0; idu_flush = 0; ldst_resume = 0; wb_resume = 0;
        @(posedge brq_clk); #1;
        cyc(1, 0, 0, 0, 0);
        check("reset_state", 64'(b_state), 64'd0);
        check("reset_cnt", 64'(b_cnt), 64'd0);
        check("reset_tmo", 64'(b_timeout), 64'd0);

        // Load-use stall, resume in the third wait cycle.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check("t1_drain", 64'(b_state), 64'd3);
        cyc(0, 0, 0, 0, 0);
        check("t1_run", 64'(b_state), 64'd0);
        check("t1_cnt", 64'(b_cnt), 64'd4);

        // Flush wins over a stall code in the same RUN cycle.
        cyc(1, 0, 0, 0, 0);
        big_flush_pulses = 0;
        cyc(0, 2, 1, 0, 0);
        check("t2_state", 64'(b_state), 64'd0);
        check("t2_cnt", 64'(b_cnt), 64'd0);
        check("t2_flush", 64'(big_flush_pulses), 64'd1);

        // Two redirects during WAIT_WB merge into one DRAIN flush.
        cyc(0, 2, 0, 0, 0);
        big_flush_pulses = 0;
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        check("t3_nopulse", 64'(big_flush_pulses), 64'd0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        idle(2);
        check("t3_onepulse", 64'(big_flush_pulses), 64'd1);

        // Watchdog on the small instance, stall code held for the rest of the run.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0);
        check("t4_drain", 64'(s_state), 64'd3);
        check("t4_tmo", 64'(s_timeout), 64'd1);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0);
        check("t4_tmo_sticky", 64'(s_timeout), 64'd1);
        check("t5_sat", 64'(s_cnt), 64'hF);

        // Reset while stalled with a redirect pending.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("t6_state", 64'(b_state), 64'd0);
        big_flush_pulses = 0;
        cyc(0, 0, 0, 1, 0);
        idle(4);
        check("t6_noflush", 64'(big_flush_pulses), 64'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 63) == 0), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
